// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes cpu byte accesses into RAM or memory-mapped I/O,
// buffers UART output in a TX FIFO and keeps the free-running cycle counter.
module mem_io_bridge #(
  parameter int TX_DEPTH_BIT = 4,
  parameter int FULL_MARGIN  = 2,
  parameter int RAM_ADDR_BIT = 17
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [31:0]             cpu_a,
  input  logic [7:0]              cpu_dout,
  input  logic                    cpu_wr,
  output logic [7:0]              cpu_din,
  output logic                    io_buffer_full,
  output logic                    ram_en,
  output logic                    ram_wr,
  output logic [RAM_ADDR_BIT-1:0] ram_a,
  output logic [7:0]              ram_din,
  input  logic [7:0]              ram_dout,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_pop,
  output logic                    program_end
);

  localparam int DEPTH = 1 << TX_DEPTH_BIT;
  localparam logic [TX_DEPTH_BIT:0] CNT_ONE  = (TX_DEPTH_BIT+1)'(1);
  localparam logic [TX_DEPTH_BIT:0] CNT_FULL = (TX_DEPTH_BIT+1)'(DEPTH);
  localparam logic [TX_DEPTH_BIT:0] FULL_LVL = (TX_DEPTH_BIT+1)'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_RX, SRC_CNT} src_e;

  logic is_io, rd_req, wr_req, sel_rx, sel_cnt, sel_stop;
  src_e src_q, src_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  rx_q, rx_d;
  logic [31:0] snap_q, snap_d, cnt_q, cnt_d;
  logic        end_q, end_d;

  logic [7:0]              tx_mem_q [DEPTH];
  logic [TX_DEPTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [TX_DEPTH_BIT:0]   count_q, count_d;
  logic                    full_q, full_d;
  logic                    push, pop, do_push;
  logic [7:0]              push_data;

  // Address decode; only cpu_a[17:0] is significant.
  assign is_io    = (cpu_a[17:16] == 2'b11);
  assign rd_req   = rdy_in & ~cpu_wr;
  assign wr_req   = rdy_in & cpu_wr;
  assign sel_rx   = is_io & (cpu_a[15:0] == 16'h0000);
  assign sel_stop = is_io & (cpu_a[15:0] == 16'h0004);
  assign sel_cnt  = is_io & (cpu_a[15:2] == 14'h0001);

  // RAM path is a straight pass-through, held off while in reset.
  assign ram_en  = rdy_in & ~is_io & ~rst_in;
  assign ram_wr  = ram_en & cpu_wr;
  assign ram_a   = cpu_a[RAM_ADDR_BIT-1:0];
  assign ram_din = cpu_dout;

  assign rx_pop      = rd_req & sel_rx & rx_valid & ~rst_in;
  assign program_end = end_q;

  // Read-source selection, RX capture, counter and snapshot.
  always_comb begin
    src_d  = src_q;
    idx_d  = idx_q;
    rx_d   = rx_q;
    snap_d = snap_q;
    cnt_d  = cnt_q;
    end_d  = end_q;
    if (rdy_in) cnt_d = cnt_q + 32'd1;
    if (rd_req) begin
      if (!is_io) begin
        src_d = SRC_RAM;
      end else if (sel_rx) begin
        src_d = SRC_RX;
        rx_d  = rx_valid ? rx_data : 8'h00;
      end else if (sel_cnt) begin
        src_d = SRC_CNT;
        idx_d = cpu_a[1:0];
        // Only the low byte re-latches so a 4-byte load sees one value.
        if (cpu_a[1:0] == 2'b00) snap_d = cnt_q;
      end else begin
        src_d = SRC_ZERO;
      end
    end
    if (wr_req && sel_stop) end_d = 1'b1;
  end

  // Read data mux driven from the registered source.
  always_comb begin
    cpu_din = 8'h00;
    case (src_q)
      SRC_RAM:  cpu_din = ram_dout;
      SRC_RX:   cpu_din = rx_q;
      SRC_CNT:  cpu_din = snap_q[8*idx_q +: 8];
      default:  cpu_din = 8'h00;
    endcase
  end

  // TX FIFO pointer/count update; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    push      = wr_req & ((sel_rx & (cpu_dout != 8'h00)) | sel_stop);
    push_data = sel_stop ? 8'h00 : cpu_dout;
    pop       = (count_q != '0) & tx_ready;
    do_push   = push & ((count_q != CNT_FULL) | pop);
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (pop)     head_d = head_q + TX_DEPTH_BIT'(1);
    if (do_push) tail_d = tail_q + TX_DEPTH_BIT'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d >= FULL_LVL);
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_mem_q[head_q];
  assign io_buffer_full = full_q;

  // FIFO storage needs no reset; pointers decide what is valid.
  always_ff @(posedge clk_in) begin
    if (do_push) tx_mem_q[tail_q] <= push_data;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      src_q   <= SRC_ZERO;
      idx_q   <= 2'b00;
      rx_q    <= 8'h00;
      snap_q  <= 32'h0;
      cnt_q   <= 32'h0;
      end_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      idx_q   <= idx_d;
      rx_q    <= rx_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the cpu top's memory bus (mem_a / mem_dout / mem_wr / mem_din) and upstream of the 128 KB RAM and the UART.
- Decodes each byte access as RAM or memory-mapped I/O and returns read data one cycle later.
- Buffers UART output in a TX FIFO and drives io_buffer_full back to the cpu.
- Maintains the cycle counter read at 0x30004 and raises the program-stop indication.

Parameters:
- TX_DEPTH_BIT, 4, log2 of TX FIFO depth (16 entries).
- FULL_MARGIN, 2, io_buffer_full asserts when free entries <= FULL_MARGIN; covers cpu reaction latency.
- RAM_ADDR_BIT, 17, RAM byte address width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  cpu-side accesses and cycle counter frozen when low
- cpu_a  in  32  byte address from cpu (only 17:0 decoded)
- cpu_dout  in  8  write data from cpu
- cpu_wr  in  1  1 = write, 0 = read
- cpu_din  out  8  read data to cpu, valid the cycle after the read request
- io_buffer_full  out  1  TX FIFO nearly full
- ram_en  out  1  RAM access enable
- ram_wr  out  1  RAM write
- ram_a  out  RAM_ADDR_BIT  RAM address
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data, synchronous, 1-cycle latency
- tx_data  out  8  UART TX byte
- tx_valid  out  1  TX byte available
- tx_ready  in  1  UART accepts byte this cycle
- rx_data  in  8  UART RX byte
- rx_valid  in  1  RX byte available
- rx_pop  out  1  consume RX byte
- program_end  out  1  sticky stop indication

Behaviour:
- Decode: is_io = (cpu_a[17:16] == 2'b11). RAM path is combinational pass-through.
  - ram_en = rdy_in & ~is_io
  - ram_wr = ram_en & cpu_wr
  - ram_a = cpu_a[RAM_ADDR_BIT-1:0]
  - ram_din = cpu_dout
- Read-source register, updated only when rdy_in = 1 and cpu_wr = 0. Values: SRC_RAM, SRC_RX, SRC_CNT(byte index 0..3), SRC_ZERO.
- cpu_din is combinational from the source register:
  - SRC_RAM selects ram_dout.
  - SRC_RX selects the registered rx byte.
  - SRC_CNT selects the indexed byte of the snapshot.
  - SRC_ZERO returns 0x00.
- Read 0x30000: if rx_valid, rx_pop = 1 for one cycle and rx_data is captured into the RX register; otherwise the RX register is set to 0x00. rx_pop is never asserted without rx_valid.
- Read 0x30004: cycle counter (32-bit) is copied into the snapshot; the returned byte is snapshot bits 7:0.
- Reads 0x30005..0x30007 return snapshot bytes 1..3 without re-latching, so a 4-byte load is coherent.
- Other I/O reads return 0x00.
- Cycle counter: reset 0; +1 every clk_in with rdy_in = 1; wraps from 0xFFFFFFFF to 0.
- Write 0x30000:
  - Non-zero byte: pushed to the TX FIFO.
  - Byte 0x00: ignored.
- Write 0x30004: program_end is set sticky, and 0x00 is pushed to the TX FIFO (stop marker for the host).
- TX FIFO: circular, 2^TX_DEPTH_BIT entries, head/tail pointers plus a count of width TX_DEPTH_BIT+1.
  - tx_valid = (count != 0); tx_data = mem[head].
  - Pop on tx_valid & tx_ready.
  - Draining continues while rdy_in = 0.
  - Simultaneous push and pop: count unchanged, both pointers advance; allowed even when full.
  - Push while full with no pop: byte dropped, state unchanged.
  - Pointers wrap modulo depth.
- io_buffer_full = (2^TX_DEPTH_BIT - count) <= FULL_MARGIN, registered (one-cycle lag covered by FULL_MARGIN).
- Reset values, asynchronous, any time including mid-access:
  - FIFO pointers and count 0; tx_valid 0; io_buffer_full 0.
  - Counter 0, snapshot 0, RX register 0, source SRC_ZERO, cpu_din 0x00.
  - program_end 0; rx_pop 0.
  - ram_en / ram_wr follow rdy_in/cpu inputs (combinational) but are forced to 0 while rst_in is high.
- rdy_in = 0: no RAM enable, no FIFO push, no rx_pop, counter and source register hold.

Test Plan:
- RAM round trip: write 0xA5 to 0x00123, then read 0x00123 -> ram_wr pulse with ram_a = 0x00123; the cycle after the read, cpu_din = 0xA5.
- UART output: write 0x48, 0x00, 0x69 to 0x30000 with tx_ready = 1 -> tx_data stream 0x48, 0x69 only; FIFO empty afterwards.
- Back-pressure: tx_ready = 0, 14 pushes -> io_buffer_full rises the cycle after the 14th push. Then 3 more pushes -> 16 stored, 17th dropped. Then tx_ready = 1 -> 16 bytes drained in order, io_buffer_full falls.
- Counter: reset, 100 cycles with rdy_in = 1, 20 with rdy_in = 0, then read 0x30004..0x30007 -> returns 100 (plus the cycles before the read), little-endian, coherent across all 4 bytes; counter does not move during the rdy_in = 0 window.
- Stop: write to 0x30004 -> program_end = 1 sticky, tx_data 0x00 emitted. Async reset mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
- RX: rx_valid = 1 with rx_data = 0x37, read 0x30000 -> rx_pop single-cycle pulse, cpu_din = 0x37. Repeat with rx_valid = 0 -> cpu_din = 0x00, no pop.
